pow_dispatch: RTL
=================

# pow_dispatch

Request front-end for the iterative 32-bit power engine (`start`/`done`/`result`, operands `a`, `b`). It buffers (base, exponent) requests from a valid/ready stream in a small FIFO and issues them one at a time to the engine. It holds the operands stable while the engine runs, captures the engine result, and presents it on a valid/ready response stream. It sits directly upstream of the engine and owns its `start` and operand inputs.

## Interface
- `W`, 32: operand/result width; must match the engine.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; also drives the engine's reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full.
- `req_base` in W: base operand.
- `req_exp` in W: exponent operand.
- `rsp_valid` out 1: result held in the response register.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_result` out W: base^exp mod 2^W.
- `pw_start` out 1: engine `start`, registered.
- `pw_a` out W: engine `a`, registered.
- `pw_b` out W: engine `b`, registered.
- `pw_done` in 1: engine `done`.
- `pw_result` in W: engine `result`.
- `jobs_done` out 16: count of responses handed off; wraps at 2^16.

## Operation
- Reset values: `req_ready`=0 during reset, then 1. `rsp_valid`=0. `rsp_result`=0. `pw_start`=0. `pw_a`=0. `pw_b`=0. `jobs_done`=0. FIFO empty. FSM in IDLE.
- FIFO:
  - Push on `req_valid && req_ready`.
  - `req_ready` = !full, from registered count only; no combinational path from the pop.
  - Full FIFO with a simultaneous pop: no push that cycle.
  - Read and write pointers wrap modulo DEPTH; count is DEPTH+1 states wide.
- FSM states:
  - IDLE:
    - Condition to leave: FIFO non-empty and `pw_done`=1.
    - Actions: pop the head, load `pw_a`/`pw_b` from the head, `pw_start`<=1, go to ISSUE.
    - If `pw_done`=0, which happens in the cycle right after reset, stay in IDLE.
  - ISSUE: `pw_start`<=0, go to WAIT_BUSY.
  - WAIT_BUSY: when `pw_done`=0, go to WAIT_DONE.
  - WAIT_DONE: when `pw_done`=1, `rsp_result`<=`pw_result`, `rsp_valid`<=1, go to RESP.
  - RESP: on `rsp_ready`=1, `rsp_valid`<=0, `jobs_done`++, go to IDLE.
- `pw_a`/`pw_b` hold their values from ISSUE until the next IDLE pop. The engine samples its operands one cycle after it sees `start`, so this hold is mandatory.
- Only one job is in flight at a time. The response register is single-entry; the engine stays idle while RESP is back-pressured.
- Arithmetic is done entirely by the engine; the result wraps modulo 2^W.
- Reset mid-operation: the FSM, FIFO and response register clear. The engine resets in the same cycle. Queued and in-flight jobs are dropped and no response is produced for them.

## Timing
- A request accepted at edge t, into an empty FIFO with the FSM in IDLE and the engine idle:
  - `pw_start`=1 during cycle t+1..t+2 (one cycle exactly).
  - `rsp_valid` rises one cycle after `pw_done` returns to 1.
- Dispatcher overhead per job, excluding engine cycles: 4 cycles (IDLE pop, ISSUE, WAIT_BUSY, WAIT_DONE capture).
- Back-to-back jobs: the next pop happens the cycle after the RESP handshake.
- A request can be accepted in any FSM state while the FIFO is not full.

## Configuration
- `POW_DISPATCH_SHORTCUT_EN` defined, in IDLE with a non-empty FIFO:
  - Head exp==0: pop, `rsp_result`<=1, `rsp_valid`<=1, go to RESP. The engine is not started and `pw_done` is ignored.
  - Head exp==1: same, with `rsp_result`<=base.
  - Shortcut jobs complete one cycle after the pop.
- Not defined: every job goes through the engine. Results are identical either way; only latency differs.

## Structure
- Shared package `pow_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP).
  - Default `W`.
  - Job struct {base, exp}.
- Sub-module `pow_req_fifo`: parameterised sync FIFO with push/pop/full/empty/count. The FSM stays in `pow_dispatch`.

## Test plan
- Single job: base=3, exp=5, dispatcher wired to the real engine.
  - `rsp_result`=243.
  - `pw_start` high for exactly one cycle.
  - `pw_a`/`pw_b` stable until `rsp_valid`.
  - `jobs_done`=1.
- Overflow: base=2, exp=32 → `rsp_result`=0. Base=2, exp=10 → 1024.
- Fill FIFO with `rsp_ready`=0:
  - After DEPTH+1 accepted requests (DEPTH queued plus one in the response register after the first pop), `req_ready`=0.
  - Release `rsp_ready`: results arrive in order.
  - No push occurs while full, even on a pop cycle.
- Exp=0: base=7, exp=0 → 1.
  - With `POW_DISPATCH_SHORTCUT_EN`: `pw_start` never asserts and the response arrives 1 cycle after the pop.
  - Without the macro: result still 1, through the engine.
- Reset mid-job: assert `reset` during WAIT_DONE with 2 jobs queued.
  - Next cycle: `rsp_valid`=0, `req_ready`=1, FIFO empty, `jobs_done`=0.
  - A subsequent job base=5, exp=3 → 125.
- Random stream: 200 jobs with random `rsp_ready` back-pressure, checked against a reference model. `jobs_done`=200 at the end.

Source files
------------

// File: rtl/pow_pkg.sv
// rtl/pow_pkg.sv - shared types for the power-engine request front-end
package pow_pkg;

    localparam int POW_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } pow_state_t;

    typedef struct packed {
        logic [POW_W-1:0] base;
        logic [POW_W-1:0] exp;
    } pow_job_t;

endpackage

// File: rtl/pow_req_fifo.sv
// rtl/pow_req_fifo.sv - synchronous request FIFO with push/pop/full/empty/count
module pow_req_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pow_dispatch.sv
// rtl/pow_dispatch.sv - queues (base, exp) requests and issues them one at a time to the power engine
// Optional build macro POW_DISPATCH_SHORTCUT_EN answers exp==0/1 without starting the engine.
module pow_dispatch
    import pow_pkg::*;
#(
    parameter int W     = POW_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_base,
    input  logic [W-1:0] req_exp,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         pw_start,
    output logic [W-1:0] pw_a,
    output logic [W-1:0] pw_b,
    input  logic         pw_done,
    input  logic [W-1:0] pw_result,
    output logic [15:0]  jobs_done
);

    localparam int CW = $clog2(DEPTH+1);

    pow_state_t    state;
    pow_job_t      wjob;
    pow_job_t      head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          shortcut;
    logic [CW-1:0] fifo_count;

    assign wjob      = '{base: req_base, exp: req_exp};
    assign req_ready = !full && !reset;
    assign push      = req_valid && req_ready;

    pow_req_fifo #(
        .WIDTH ($bits(pow_job_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wjob),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        shortcut = 1'b0;
`ifdef POW_DISPATCH_SHORTCUT_EN
        shortcut = (head.exp == '0) || (head.exp == POW_W'(1));
`endif
        // Engine jobs wait for done so the engine is known idle before start.
        pop = (state == IDLE) && !empty && (pw_done || shortcut);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pw_start   <= 1'b0;
            pw_a       <= '0;
            pw_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            jobs_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (shortcut) begin
                            rsp_result <= (head.exp == '0) ? W'(1) : head.base;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            pw_a     <= head.base;
                            pw_b     <= head.exp;
                            pw_start <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    pw_start <= 1'b0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!pw_done) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (pw_done) begin
                        rsp_result <= pw_result;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_bound: assert property (@(posedge clk) disable iff (reset) fifo_count <= CW'(DEPTH));

endmodule
